// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, responder state encoding and a width helper.
package apb_pkg;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Bit width needed to hold values below v, never less than one bit.
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array behind the APB responder: one 32-bit word per register, a
// one-cycle write strobe per register and a read mux indexed by the latched word index.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int IDX_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [IDX_W-1:0]       idx,
    input  logic [APB_DW-1:0]      wdata,
    output logic [APB_DW-1:0]      rdata,
    output logic [NREG*APB_DW-1:0] reg_q,
    output logic [NREG-1:0]        wr_stb
);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [APB_DW-1:0] word_q;
            logic              stb_q;
            logic              hit;

            assign hit = we && (idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                    stb_q  <= 1'b0;
                end else begin
                    stb_q <= hit;
                    if (hit) begin
                        word_q <= wdata;
                    end
                end
            end

            assign reg_q[gi*APB_DW +: APB_DW] = word_q;
            assign wr_stb[gi]                 = stb_q;
        end
    endgenerate

    // Indices past the last register read as zero; the top flags them as errors anyway.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IDX_W'(i)) begin
                rdata = reg_q[i*APB_DW +: APB_DW];
            end
        end
    end

endmodule

// File: rtl/apb_slave_regs.sv
// APB responder for a bank of control/status registers with a fixed number of
// wait states; the transfer FSM, wait counter and address decode live here.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int NREG     = 8,
    parameter int WAIT_CYC = 2,
    parameter int ADDR_LSB = 2
) (
    input  logic                   Pclk,
    input  logic                   Presetn,
    input  logic                   Psel,
    input  logic                   Penable,
    input  logic                   Pwrite,
    input  logic [APB_AW-1:0]      Paddr,
    input  logic [APB_DW-1:0]      Pdata,
    output logic [APB_DW-1:0]      Prdata,
    output logic                   Pready,
    output logic                   Pslverr,
    output logic [NREG*APB_DW-1:0] reg_q,
    output logic [NREG-1:0]        wr_stb
);

    localparam int IDX_W = clog2_min1(NREG);
    localparam int CNT_W = clog2_min1(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYC);
    localparam logic [APB_AW-1:0] LSB_MASK = APB_AW'((64'd1 << ADDR_LSB) - 64'd1);

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              dir_q, dir_d;
    logic              err_q, err_d;

    logic [IDX_W-1:0]  setup_idx;
    logic [APB_AW-1:0] setup_word;
    logic              setup_err;
    logic              we;
    logic [APB_DW-1:0] bank_rdata;

    // The full word index catches both out-of-range indices and stray upper address bits.
    assign setup_idx  = Paddr[ADDR_LSB +: IDX_W];
    assign setup_word = Paddr >> ADDR_LSB;
    assign setup_err  = (|(Paddr & LSB_MASK)) || (setup_word >= APB_AW'(NREG));

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (Psel && !Penable) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    idx_d   = setup_idx;
                    dir_d   = Pwrite;
                    err_d   = setup_err;
                end
            end
            ACCESS: begin
                if (!Psel) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A commit needs Psel still asserted in the ready cycle; a dropped select aborts.
    always_comb begin
        Pready  = (state_q == ACCESS) && (cnt_q == '0);
        Pslverr = Pready && err_q;
        we      = Pready && Psel && dir_q && !err_q;
        Prdata  = (Pready && !dir_q && !err_q) ? bank_rdata : '0;
    end

    apb_reg_bank #(
        .NREG  (NREG),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk    (Pclk),
        .rst_n  (Presetn),
        .we     (we),
        .idx    (idx_q),
        .wdata  (Pdata),
        .rdata  (bank_rdata),
        .reg_q  (reg_q),
        .wr_stb (wr_stb)
    );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Randomized APB traffic into two responders (2 and 0 wait states), checked every
// cycle against a transfer-level model, plus directed literal checks.
module tb_apb_slave_regs;

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pdata   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic [255:0] regq   [2];
    logic [7:0]  stb     [2];

    int checks = 0;
    int passes = 0;

    apb_slave_regs #(.NREG(8), .WAIT_CYC(2), .ADDR_LSB(2)) dut_w2 (
        .Pclk(clk), .Presetn(rst_n), .Psel(psel[0]), .Penable(penable[0]),
        .Pwrite(pwrite[0]), .Paddr(paddr[0]), .Pdata(pdata[0]), .Prdata(prdata[0]),
        .Pready(pready[0]), .Pslverr(pslverr[0]), .reg_q(regq[0]), .wr_stb(stb[0])
    );

    apb_slave_regs #(.NREG(8), .WAIT_CYC(0), .ADDR_LSB(2)) dut_w0 (
        .Pclk(clk), .Presetn(rst_n), .Psel(psel[1]), .Penable(penable[1]),
        .Pwrite(pwrite[1]), .Paddr(paddr[1]), .Pdata(pdata[1]), .Prdata(prdata[1]),
        .Pready(pready[1]), .Pslverr(pslverr[1]), .reg_q(regq[1]), .wr_stb(stb[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= 8);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transfer-level model: one pending transfer per responder, aged in cycles since setup.
    bit          m_busy [2];
    int          m_age  [2];
    bit          m_wr   [2];
    bit          m_err  [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_regs [2][8];
    logic [7:0]  m_stb  [2];

    always @(negedge clk) begin : cmp
        bit          e_rdy;
        logic [31:0] e_rd;
        logic [255:0] e_regq;
        logic [7:0]  nstb;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_age[k] = 0; m_stb[k] = '0;
                for (int i = 0; i < 8; i++) m_regs[k][i] = '0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            e_rdy = m_busy[k] && (m_age[k] == wait_of(k));
            e_rd  = (e_rdy && !m_wr[k] && !m_err[k]) ? m_regs[k][(m_addr[k] >> 2) & 7] : 32'h0;
            for (int i = 0; i < 8; i++) e_regq[32*i +: 32] = m_regs[k][i];
            chk($sformatf("w%0d_pready", wait_of(k)), 256'(pready[k]), 256'(e_rdy));
            chk($sformatf("w%0d_pslverr", wait_of(k)), 256'(pslverr[k]), 256'(e_rdy && m_err[k]));
            chk($sformatf("w%0d_prdata", wait_of(k)), 256'(prdata[k]), 256'(e_rd));
            chk($sformatf("w%0d_reg_q", wait_of(k)), regq[k], e_regq);
            chk($sformatf("w%0d_wr_stb", wait_of(k)), 256'(stb[k]), 256'(m_stb[k]));
        end
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                nstb = '0;
                if (m_busy[k]) begin
                    if (!psel[k]) begin
                        m_busy[k] = 0;
                    end else if (m_age[k] == wait_of(k)) begin
                        if (m_wr[k] && !m_err[k]) begin
                            m_regs[k][m_addr[k] >> 2] = pdata[k];
                            nstb[m_addr[k] >> 2] = 1'b1;
                        end
                        m_busy[k] = 0;
                    end else begin
                        m_age[k]++;
                    end
                end else if (psel[k] && !penable[k]) begin
                    m_busy[k] = 1; m_age[k] = 0;
                    m_wr[k] = pwrite[k]; m_addr[k] = paddr[k]; m_err[k] = addr_bad(paddr[k]);
                end
                m_stb[k] = nstb;
            end
        end
    end

    // Starts at #1 after a rising edge and returns at #1 after the edge that follows Pready.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int abort_at, output logic [31:0] rd, output bit serr,
                        output int lat, output bit done);
        int acc;
        bit fin;
        psel[k] = 1; penable[k] = 0; pwrite[k] = wr; paddr[k] = addr; pdata[k] = data;
        rd = '0; serr = 0; done = 0; fin = 0; acc = 0; lat = 0;
        @(posedge clk); #1;
        penable[k] = 1; lat = 1;
        while (!fin) begin
            @(negedge clk);
            if (pready[k]) begin
                rd = prdata[k]; serr = pslverr[k]; done = 1; fin = 1;
            end else if (acc == abort_at) begin
                fin = 1;
            end else if (lat > 40) begin
                chk("xfer_timeout", 256'(0), 256'(1));
                fin = 1;
            end
            @(posedge clk); #1;
            if (!fin) begin lat++; acc++; end
        end
        psel[k] = 0; penable[k] = 0;
    endtask

    logic [31:0] rd;
    bit          serr, done;
    int          lat;

    initial begin
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            psel[k] = 0; penable[k] = 0; pwrite[k] = 0; paddr[k] = '0; pdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Reset in the middle of an access clears everything.
        xfer(0, 1, 32'h00, 32'h1234_5678, -1, rd, serr, lat, done);
        psel[0] = 1; pwrite[0] = 1; paddr[0] = 32'h0C; pdata[0] = 32'hCAFE_0001;
        @(posedge clk); #1 penable[0] = 1;
        #2 rst_n = 0;
        @(negedge clk);
        chk("rst_pready", 256'(pready[0]), 256'(0));
        chk("rst_pslverr", 256'(pslverr[0]), 256'(0));
        chk("rst_prdata", 256'(prdata[0]), 256'(0));
        chk("rst_reg_q", regq[0], 256'(0));
        chk("rst_wr_stb", 256'(stb[0]), 256'(0));
        @(posedge clk); #1 psel[0] = 0; penable[0] = 0;
        @(posedge clk); #1 rst_n = 1;
        xfer(0, 0, 32'h00, 32'h0, -1, rd, serr, lat, done);
        chk("post_rst_read", 256'(rd), 256'(32'h0));
        chk("post_rst_serr", 256'(serr), 256'(0));

        // Write then read with two wait states.
        xfer(0, 1, 32'h08, 32'hDEAD_BEEF, -1, rd, serr, lat, done);
        chk("wr_latency", 256'(lat), 256'(3));
        chk("wr_serr", 256'(serr), 256'(0));
        chk("wr_stb_pulse", 256'(stb[0]), 256'(8'b0000_0100));
        chk("wr_reg2", 256'(regq[0][95:64]), 256'(32'hDEAD_BEEF));
        @(posedge clk); #1;
        chk("wr_stb_single", 256'(stb[0]), 256'(0));
        xfer(0, 0, 32'h08, 32'h0, -1, rd, serr, lat, done);
        chk("rd_reg2", 256'(rd), 256'(32'hDEAD_BEEF));

        // Error accesses.
        xfer(0, 1, 32'h20, 32'h1111_1111, -1, rd, serr, lat, done);
        chk("err_idx8_serr", 256'(serr), 256'(1));
        chk("err_idx8_stb", 256'(stb[0]), 256'(0));
        xfer(0, 1, 32'h05, 32'h2222_2222, -1, rd, serr, lat, done);
        chk("err_misalign_serr", 256'(serr), 256'(1));
        chk("err_reg_q", regq[0], {160'h0, 32'hDEAD_BEEF, 64'h0});
        xfer(0, 0, 32'h20, 32'h0, -1, rd, serr, lat, done);
        chk("err_rd_data", 256'(rd), 256'(0));
        chk("err_rd_serr", 256'(serr), 256'(1));

        // Back-to-back with zero wait states.
        xfer(1, 1, 32'h00, 32'h1, -1, rd, serr, lat, done);
        chk("b2b_wr_latency", 256'(lat), 256'(1));
        xfer(1, 0, 32'h00, 32'h0, -1, rd, serr, lat, done);
        chk("b2b_rd_latency", 256'(lat), 256'(1));
        chk("b2b_rd_data", 256'(rd), 256'(32'h1));

        // Abort during a wait cycle.
        xfer(0, 1, 32'h04, 32'hA5A5_A5A5, 0, rd, serr, lat, done);
        chk("abort_no_ready", 256'(done), 256'(0));
        repeat (2) @(posedge clk);
        #1 chk("abort_no_write", 256'(regq[0][63:32]), 256'(0));
        xfer(0, 1, 32'h04, 32'h0BAD_F00D, -1, rd, serr, lat, done);
        chk("after_abort_done", 256'(done), 256'(1));
        xfer(0, 0, 32'h04, 32'h0, -1, rd, serr, lat, done);
        chk("after_abort_rd", 256'(rd), 256'(32'h0BAD_F00D));

        // Access phase without a setup phase is ignored.
        psel[0] = 1; penable[0] = 1; pwrite[0] = 0; paddr[0] = 32'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_setup_pready", 256'(pready[0]), 256'(0));
        end
        @(posedge clk); #1 psel[0] = 0; penable[0] = 0;

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 300; n++) begin
            int k, r, ab;
            logic [31:0] a;
            bit w;
            k = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 7)) << 2;
            else if (r == 7) a = 32'($urandom_range(0, 31)) | 32'h1;
            else if (r == 8) a = 32'h20 + (32'($urandom_range(0, 7)) << 2);
            else             a = ($urandom() & 32'hFFFF_FFFC) | 32'h100;
            w = 1'($urandom_range(0, 1));
            ab = -1;
            if (wait_of(k) > 0 && $urandom_range(0, 9) == 0) ab = $urandom_range(0, wait_of(k) - 1);
            xfer(k, w, a, $urandom(), ab, rd, serr, lat, done);
            chk("rand_done", 256'(done), 256'(ab < 0));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_regs.md
# apb_slave_regs

APB responder holding a bank of 32-bit control/status registers, with a programmable wait-state count, sitting on the APB side of the AHB-to-APB bridge as the target that the bridge's APB master drives. It decodes word addresses and inserts wait states by holding Pready low. It commits writes, returns read data and flags bad accesses with Pslverr. Register contents and per-register write strobes are exported to the attached peripheral logic.

## Interface
- NREG, 8: number of 32-bit registers; legal word indices 0..NREG-1.
- WAIT_CYC, 2: wait states per access; 0 means Pready high in the first access cycle.
- ADDR_LSB, 2: Paddr bit where the word index starts; Paddr[ADDR_LSB-1:0] must be 0.

- Pclk  in  1  bus clock; all state on rising edge.
- Presetn  in  1  asynchronous, active-low reset.
- Psel  in  1  slave select.
- Penable  in  1  access phase.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address.
- Pdata  in  32  write data.
- Prdata  out  32  read data; valid when Pready=1 and Pwrite=0.
- Pready  out  1  transfer complete.
- Pslverr  out  1  error response; valid only with Pready=1.
- reg_q  out  NREG*32  flattened register contents; register i is reg_q[32*i+31:32*i].
- wr_stb  out  NREG  one-cycle pulse on the cycle after register i is written.

## Operation
- States: IDLE and ACCESS, with a wait counter cnt of width clog2(WAIT_CYC+1), minimum 1.
- IDLE:
  - When Psel=1 and Penable=0 at an edge, go to ACCESS and load cnt=WAIT_CYC.
  - On the same edge, latch idx=Paddr[ADDR_LSB+:clog2(NREG)] and dir=Pwrite.
  - On the same edge, latch err=1 if Paddr[ADDR_LSB-1:0]!=0, or if the index is >= NREG, or if any Paddr bits above the index are non-zero.
  - Penable=1 seen in IDLE (no setup phase) is ignored.
- ACCESS, with Pready = (state==ACCESS) & (cnt==0):
  - If Psel=0, abort: go to IDLE, no write, no wr_stb.
  - Else if cnt!=0, decrement cnt.
  - Else (Pready cycle) the transfer ends: go to IDLE.
    - On a write with err=0, reg[idx] <= Pdata, sampled in the Pready cycle.
    - On an error or read, no register changes.
- Pslverr = Pready & err.
- Prdata = reg[idx] when Pready & !dir & !err, else 0. It reflects any write committed by an earlier transfer.
- Back-to-back transfers: a setup phase in the cycle after Pready is accepted. The minimum transfer is 2 cycles (setup + access) plus WAIT_CYC.
- Reset mid-transfer: everything returns to the reset state immediately. No partial write occurs.

## Timing
- Reset values:
  - state=IDLE, cnt=0, all registers 0.
  - Prdata=0, Pready=0, Pslverr=0, wr_stb=0, reg_q=0.
- Outputs are decodes of registered state only. There is no combinational path from APB inputs to Pready, Pslverr or wr_stb.
- Latency: setup at cycle T, Penable from T+1, Pready high in cycle T+1+WAIT_CYC. A write is visible on reg_q at T+2+WAIT_CYC, with wr_stb[idx]=1 for that single cycle.
- Pready is high for exactly one cycle per transfer.

## Structure
- Shared package apb_pkg: state enum {IDLE, ACCESS}, APB_DW=32, APB_AW=32.
- Sub-module apb_reg_bank holds the register array and wr_stb generation. Its ports are clock, reset, we, idx, wdata, rdata, reg_q and wr_stb.
- FSM, counter and address decode live in the top.

## Test plan
- Reset: hold Presetn=0 mid-access -> all outputs 0; release -> read of Paddr 0x00 returns 0x00000000, Pslverr=0.
- Write/read, WAIT_CYC=2: write 0xDEADBEEF to 0x08 -> Pready exactly 3 cycles after setup; wr_stb=8'b0000_0100 one cycle; reg_q[95:64]=0xDEADBEEF. Read 0x08 -> Prdata=0xDEADBEEF.
- Errors: write to 0x20 (idx 8, NREG=8) and to 0x05 -> Pready with Pslverr=1, no wr_stb, reg_q unchanged. Read 0x20 -> Prdata=0.
- Back-to-back, WAIT_CYC=0: write 0x1 to 0x00, then read 0x00 setup in the next cycle -> each transfer takes 2 cycles; read returns 0x00000001.
- Abort: drop Psel during a wait cycle of a write to 0x04 -> no Pready, no write. The next valid transfer completes normally.
- Penable=1 with Psel=1 and no prior setup cycle -> stays IDLE, Pready stays 0.
